// File: rtl/auto_index_seq_pkg.sv
// Shared types for the auto-index sequencer: FSM state encoding, index modes
// and datapath widths.
package auto_index_seq_pkg;

    localparam int DATA_W = 16;
    localparam int PAGE_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        IDX_NONE    = 2'b00,
        IDX_POSTINC = 2'b01,
        IDX_POSTDEC = 2'b10,
        IDX_PREDEC  = 2'b11
    } idx_mode_t;

    // Plain indirect leaves memory untouched, so it skips the write-back cycle.
    function automatic logic writes_back(idx_mode_t mode);
        return mode != IDX_NONE;
    endfunction

endpackage

// File: rtl/auto_index_seq_ptr_step.sv
// Combinational +/-1 step for the auto-index pointer, wrapping modulo 2^16.
module ptr_step
    import auto_index_seq_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  idx_mode_t         mode,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] ONE = 1;

    always_comb begin
        result = value;
        case (mode)
            IDX_POSTINC: result = value + ONE;
            IDX_POSTDEC,
            IDX_PREDEC:  result = value - ONE;
            default:     result = value;
        endcase
    end

endmodule

// File: rtl/auto_index_seq.sv
// Auto-index sequencer: reads a page-zero pointer, optionally steps it by +/-1,
// writes it back and reports the effective pointer.
module auto_index_seq
    import auto_index_seq_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [DATA_W-1:0] ir,
    input  logic [1:0]        idx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] ptr
);

    state_t            state;
    state_t            next_state;
    logic [PAGE_W-1:0] page_q;
    idx_mode_t         mode_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] new_q;
    logic [DATA_W-1:0] ptr_q;
    logic [DATA_W-1:0] step_result;

    // The upper instruction bits belong to the upstream decoder, not this block.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[DATA_W-1:PAGE_W];

    ptr_step u_ptr_step (
        .value  (old_q),
        .mode   (mode_q),
        .result (step_result)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = ST_READ;
                end
            end
            ST_READ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                next_state = writes_back(mode_q) ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Operands are latched at start so later ir/idx changes cannot disturb the bus.
    // In CALC with plain indirect new_q is stale, but ptr then takes old_q anyway.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            page_q <= '0;
            mode_q <= IDX_NONE;
            old_q  <= '0;
            new_q  <= '0;
            ptr_q  <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                page_q <= ir[PAGE_W-1:0];
                mode_q <= idx_mode_t'(idx);
            end
            if (state == ST_READ && mem_ack) begin
                old_q <= mem_rdata;
            end
            if (state == ST_CALC) begin
                new_q <= step_result;
            end
            if (next_state == ST_DONE && state != ST_DONE) begin
                ptr_q <= (mode_q == IDX_PREDEC) ? new_q : old_q;
            end
        end
    end

    assign mem_addr  = {{(DATA_W-PAGE_W){1'b0}}, page_q};
    assign mem_wdata = new_q;
    assign ptr       = ptr_q;

endmodule

// File: doc/auto_index_seq.md
AUTO_INDEX_SEQ -- requirements
Module: auto_index_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; its ports are clk and nreset.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 nreset  in  1  asynchronous active-low reset.
REQ-004 start  in  1  request to begin one auto-index operation; sampled on the rising edge of clk.
REQ-005 ir  in  16  instruction register; only ir[9:0] (the page-zero pointer location) is used.
REQ-006 idx  in  2  auto-index mode from the upstream auto-index decoder:
- 00 plain indirect
- 01 post-increment
- 10 post-decrement
- 11 pre-decrement
REQ-007 mem_req  out  1  memory cycle request.
REQ-008 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-009 mem_addr  out  16  memory address; equals {6'b0, ir[9:0]} as latched at start.
REQ-010 mem_wdata  out  16  write data.
REQ-011 mem_rdata  in  16  read data; valid when mem_ack=1.
REQ-012 mem_ack  in  1  memory cycle complete; sampled on the rising edge of clk.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 ptr  out  16  effective pointer result; held stable from done until the next accepted start.

Function
REQ-016 States SHALL be IDLE, READ, CALC, WRITE and DONE.
REQ-017 In IDLE, start=1 SHALL latch ir[9:0] and idx and move to READ; start is ignored in every other state.
REQ-018 READ: mem_req=1, mem_we=0; remain in READ until mem_ack=1, then latch mem_rdata as old and go to CALC.
REQ-019 CALC (exactly one cycle):
- new = old+1 for idx=01; old-1 for idx=10 or 11; old for idx=00.
- Arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000 and 16'h0000-1 = 16'hFFFF.
- Next state is WRITE, or DONE when idx=00.
REQ-020 WRITE: mem_req=1, mem_we=1, mem_wdata=new; remain in WRITE until mem_ack=1, then go to DONE.
REQ-021 ptr SHALL be loaded on entry to DONE:
- old for idx=00, 01 and 10.
- new for idx=11.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE; start is not accepted in DONE.
REQ-023 Latency with zero-wait-state memory (mem_ack=1 in the first request cycle):
- done SHALL be high in the 4th cycle after the start edge for idx≠00.
- done SHALL be high in the 3rd cycle after the start edge for idx=00.
REQ-024 Each additional wait cycle on mem_ack SHALL add exactly one cycle to the latency.
REQ-025 mem_ack outside READ or WRITE SHALL be ignored.
REQ-026 mem_addr and mem_wdata SHALL stay constant while mem_req=1, and SHALL not change when ir or idx change after start.

Reset
REQ-027 While nreset=0 the block SHALL be in IDLE, asynchronously, with mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0 and ptr=0.
REQ-028 If reset is asserted mid-operation, the operation SHALL be abandoned with no write issued after reset.
REQ-029 After nreset rises, the block SHALL accept start from the next rising edge of clk.

Structure
REQ-030 The state encoding and the idx mode constants (IDX_NONE, IDX_POSTINC, IDX_POSTDEC, IDX_PREDEC) SHALL be defined in a shared package or include file.
REQ-031 The ±1 datapath SHALL be one sub-module, ptr_step (16-bit in, mode in, 16-bit out, purely combinational).
REQ-032 The upstream auto-index decoder SHALL drive idx; this block SHALL not re-decode ir[11:6].

Verification
REQ-033 Each of the following directed scenarios SHALL be run:
- idx=01, ir[9:0]=10'h3C0, memory[0x03C0]=0x1234, zero-wait -> read 0x03C0, write 0x1235, ptr=0x1234, done in cycle 4.
- idx=01, memory=0xFFFF -> write 0x0000, ptr=0xFFFF; idx=10, memory=0x0000 -> write 0xFFFF, ptr=0x0000.
- idx=11, memory=0x0100 -> write 0x00FF, ptr=0x00FF; idx=00, memory=0x0100 -> no write cycle, ptr=0x0100, done in cycle 3.
- idx=01 with mem_ack delayed 2 cycles on the read and 3 on the write -> done in cycle 9; mem_addr and mem_wdata stable while mem_req=1.
- nreset pulsed low during WRITE before mem_ack -> mem_req=0 immediately, all outputs at reset values, next start completes normally.
- start held high continuously -> operations back-to-back, one per IDLE visit; start ignored while busy=1.
